// File: rtl/coin_pkg.sv
// Shared coin-path definitions: coin codes, acceptor FSM states and default pulse-width windows.
package coin_pkg;

    localparam logic COIN_FIVE = 1'b0;
    localparam logic COIN_TEN  = 1'b1;

    localparam int unsigned DEBOUNCE_CYC_DEF = 4;
    localparam int unsigned FIVE_MIN_DEF     = 8;
    localparam int unsigned FIVE_MAX_DEF     = 15;
    localparam int unsigned TEN_MIN_DEF      = 20;
    localparam int unsigned TEN_MAX_DEF      = 31;
    localparam int unsigned FIFO_DEPTH_DEF   = 4;
    localparam int unsigned GAP_CYC_DEF      = 2;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StClassify
    } coin_state_e;

    function automatic logic in_window(input int unsigned w, input int unsigned lo,
                                       input int unsigned hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: sensor and credit-enable inputs, coin strobes and queue status outputs.
interface coin_acceptor_if import coin_pkg::*; #(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) ();
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    logic              coin_sense;
    logic              accept_en;
    logic              five_rup;
    logic              ten_rup;
    logic              coin_reject;
    logic [CountW-1:0] coins_queued;

    modport master (
        output coin_sense,
        output accept_en,
        input  five_rup,
        input  ten_rup,
        input  coin_reject,
        input  coins_queued
    );

    modport slave (
        input  coin_sense,
        input  accept_en,
        output five_rup,
        output ten_rup,
        output coin_reject,
        output coins_queued
    );

endinterface

// File: rtl/coin_fifo.sv
// Small synchronous FIFO; a push while full is accepted only if a pop happens in the same cycle.
module coin_fifo #(
    parameter int unsigned Depth  = 4,
    parameter int unsigned Width  = 1,
    localparam int unsigned AddrW  = $clog2(Depth),
    localparam int unsigned CountW = AddrW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [Width-1:0]  wdata,
    input  logic              pop,
    output logic [Width-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [CountW-1:0] count
);

    logic [Width-1:0]  mem_q [Depth];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              wr_en, rd_en;

    assign full  = (count_q == CountW'(Depth));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: synchronise and debounce the sensor, classify pulse width, queue coins and
// release them as spaced one-cycle credit strobes.
module coin_acceptor import coin_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned FIVE_MIN     = FIVE_MIN_DEF,
    parameter int unsigned FIVE_MAX     = FIVE_MAX_DEF,
    parameter int unsigned TEN_MIN      = TEN_MIN_DEF,
    parameter int unsigned TEN_MAX      = TEN_MAX_DEF,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int unsigned GAP_CYC      = GAP_CYC_DEF
) (
    input logic           clk,
    input logic           rst_n,
    coin_acceptor_if.slave bus
);

    localparam int unsigned WidthW = $clog2(TEN_MAX + 2);
    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned GapW   = $clog2(GAP_CYC + 2);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WidthW-1:0] WidthSat = WidthW'(TEN_MAX + 1);

    logic              sync1_q, sync2_q;
    logic              filt_q, filt_d;
    logic [DbW-1:0]    db_cnt_q, db_cnt_d;
    logic [DbW-1:0]    arm_cnt_q, arm_cnt_d;
    logic              armed_q, armed_d;
    coin_state_e       state_q, state_d;
    logic [WidthW-1:0] width_q, width_d;
    logic              push_q, push_d;
    logic              push_code_q, push_code_d;
    logic              reject_q, reject_d;
    logic              five_q, five_d;
    logic              ten_q, ten_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              bad;
    logic              pop, drop;
    logic              fifo_rdata, fifo_full, fifo_empty;
    logic [CountW-1:0] fifo_count;

    // Filtered level flips on the DEBOUNCE_CYC-th consecutive disagreeing sample.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) filt_d = sync2_q;
            else db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Measuring is enabled only after a full debounced low, so a coin already in the
    // sensor at reset release is never counted.
    always_comb begin
        armed_d   = armed_q;
        arm_cnt_d = arm_cnt_q;
        if (!armed_q) begin
            if (!sync2_q && !filt_q) begin
                if (arm_cnt_q == DbW'(DEBOUNCE_CYC - 1)) armed_d = 1'b1;
                else arm_cnt_d = arm_cnt_q + 1'b1;
            end else begin
                arm_cnt_d = '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        push_d      = 1'b0;
        push_code_d = COIN_FIVE;
        bad         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (armed_q && filt_q) begin
                    state_d = StMeasure;
                    width_d = WidthW'(1);
                end
            end
            StMeasure: begin
                if (!filt_q) state_d = StClassify;
                else if (width_q != WidthSat) width_d = width_q + 1'b1;
            end
            StClassify: begin
                state_d = StIdle;
                if (in_window(32'(width_q), FIVE_MIN, FIVE_MAX)) begin
                    push_d      = 1'b1;
                    push_code_d = COIN_FIVE;
                end else if (in_window(32'(width_q), TEN_MIN, TEN_MAX)) begin
                    push_d      = 1'b1;
                    push_code_d = COIN_TEN;
                end else begin
                    bad = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop  = bus.accept_en && !fifo_empty && (gap_q == '0);
    assign drop = push_q && fifo_full && !pop;

    always_comb begin
        five_d   = pop && (fifo_rdata == COIN_FIVE);
        ten_d    = pop && (fifo_rdata == COIN_TEN);
        reject_d = bad || drop;
        gap_d    = gap_q;
        if (pop) gap_d = GapW'(GAP_CYC);
        else if (gap_q != '0) gap_d = gap_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            db_cnt_q    <= '0;
            arm_cnt_q   <= '0;
            armed_q     <= 1'b0;
            state_q     <= StIdle;
            width_q     <= '0;
            push_q      <= 1'b0;
            push_code_q <= COIN_FIVE;
            reject_q    <= 1'b0;
            five_q      <= 1'b0;
            ten_q       <= 1'b0;
            gap_q       <= '0;
        end else begin
            sync1_q     <= bus.coin_sense;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            db_cnt_q    <= db_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            width_q     <= width_d;
            push_q      <= push_d;
            push_code_q <= push_code_d;
            reject_q    <= reject_d;
            five_q      <= five_d;
            ten_q       <= ten_d;
            gap_q       <= gap_d;
        end
    end

    coin_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .wdata (push_code_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.five_rup     = five_q;
    assign bus.ten_rup      = ten_q;
    assign bus.coin_reject  = reject_q;
    assign bus.coins_queued = fifo_count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: classification, latency, queueing, back-pressure and reset.
module tb_coin_acceptor;
    import coin_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   rej_cnt = 0;
    int   both_cnt = 0;
    logic code_q [$];
    int   stamp_q [$];

    localparam int Latency = int'(DEBOUNCE_CYC_DEF) + 4 + 2;  // +2 raw-to-synchroniser

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coin_acceptor_if #(.FIFO_DEPTH(FIFO_DEPTH_DEF)) bus ();

    coin_acceptor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Log every strobe with its cycle stamp; mid-cycle sampling keeps clear of the edge.
    always @(negedge clk) begin
        if (bus.five_rup) begin
            code_q.push_back(COIN_FIVE);
            stamp_q.push_back(cyc);
        end
        if (bus.ten_rup) begin
            code_q.push_back(COIN_TEN);
            stamp_q.push_back(cyc);
        end
        if (bus.five_rup && bus.ten_rup) both_cnt++;
        if (bus.coin_reject) rej_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pulse(input int w, output int drop);
        @(posedge clk);
        #1 bus.coin_sense = 1'b1;
        repeat (w) @(posedge clk);
        #1 bus.coin_sense = 1'b0;
        drop = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.coin_sense = 1'b0;
        bus.accept_en  = 1'b0;
        #2;
        n_vec++;
        if (bus.five_rup !== 1'b0 || bus.ten_rup !== 1'b0 || bus.coin_reject !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b%b%b required 000",
                     bus.five_rup, bus.ten_rup, bus.coin_reject);
        end
        n_vec++;
        if (bus.coins_queued !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_queued: got %0d required 0", bus.coins_queued);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);
    endtask

    task automatic test_five();
        int s, r, d;
        s = code_q.size();
        r = rej_cnt;
        bus.accept_en = 1'b1;
        drive_pulse(12, d);
        idle(20);
        n_vec++;
        if (code_q.size() - s !== 1) begin
            n_fail++;
            $display("FAIL five_count: got %0d required 1", code_q.size() - s);
        end else begin
            n_vec++;
            if (code_q[s] !== COIN_FIVE) begin
                n_fail++;
                $display("FAIL five_code: got %0d required 0", code_q[s]);
            end
            n_vec++;
            if (stamp_q[s] - d !== Latency) begin
                n_fail++;
                $display("FAIL five_latency: got %0d required %0d", stamp_q[s] - d, Latency);
            end
        end
        n_vec++;
        if (rej_cnt - r !== 0) begin
            n_fail++;
            $display("FAIL five_reject: got %0d required 0", rej_cnt - r);
        end
    endtask

    task automatic test_ten_and_glitch();
        int s, r, d;
        s = code_q.size();
        r = rej_cnt;
        drive_pulse(25, d);
        idle(20);
        n_vec++;
        if (code_q.size() - s !== 1) begin
            n_fail++;
            $display("FAIL ten_count: got %0d required 1", code_q.size() - s);
        end else begin
            n_vec++;
            if (code_q[s] !== COIN_TEN) begin
                n_fail++;
                $display("FAIL ten_code: got %0d required 1", code_q[s]);
            end
        end
        s = code_q.size();
        drive_pulse(3, d);
        idle(20);
        n_vec++;
        if (code_q.size() - s !== 0 || rej_cnt - r !== 0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got strobes=%0d rejects=%0d required 0/0",
                     code_q.size() - s, rej_cnt - r);
        end
    endtask

    task automatic test_invalid();
        int widths [2] = '{17, 40};
        int s, r, d;
        foreach (widths[i]) begin
            s = code_q.size();
            r = rej_cnt;
            drive_pulse(widths[i], d);
            idle(20);
            n_vec++;
            if (rej_cnt - r !== 1) begin
                n_fail++;
                $display("FAIL invalid_%0d_reject: got %0d required 1", widths[i], rej_cnt - r);
            end
            n_vec++;
            if (code_q.size() - s !== 0 || bus.coins_queued !== 3'd0) begin
                n_fail++;
                $display("FAIL invalid_%0d_quiet: got strobes=%0d queued=%0d required 0/0",
                         widths[i], code_q.size() - s, bus.coins_queued);
            end
        end
    endtask

    task automatic test_queue_overflow();
        int   widths [5] = '{12, 25, 12, 25, 12};
        logic exp_code [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   s, r, d;
        bus.accept_en = 1'b0;
        s = code_q.size();
        r = rej_cnt;
        foreach (widths[i]) begin
            drive_pulse(widths[i], d);
            idle(14);
        end
        n_vec++;
        if (bus.coins_queued !== 3'd4) begin
            n_fail++;
            $display("FAIL queue_fill: got %0d required 4", bus.coins_queued);
        end
        n_vec++;
        if (rej_cnt - r !== 1 || code_q.size() - s !== 0) begin
            n_fail++;
            $display("FAIL queue_overflow: got rejects=%0d strobes=%0d required 1/0",
                     rej_cnt - r, code_q.size() - s);
        end
        bus.accept_en = 1'b1;
        idle(20);
        n_vec++;
        if (code_q.size() - s !== 4) begin
            n_fail++;
            $display("FAIL drain_count: got %0d required 4", code_q.size() - s);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (code_q[s+i] !== exp_code[i]) begin
                    n_fail++;
                    $display("FAIL drain_order_%0d: got %0d required %0d",
                             i, code_q[s+i], exp_code[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_vec++;
                if (stamp_q[s+i] - stamp_q[s+i-1] !== int'(GAP_CYC_DEF) + 1) begin
                    n_fail++;
                    $display("FAIL drain_spacing_%0d: got %0d required %0d", i,
                             stamp_q[s+i] - stamp_q[s+i-1], GAP_CYC_DEF + 1);
                end
            end
        end
        n_vec++;
        if (bus.coins_queued !== 3'd0 || both_cnt !== 0) begin
            n_fail++;
            $display("FAIL drain_end: got queued=%0d overlap=%0d required 0/0",
                     bus.coins_queued, both_cnt);
        end
    endtask

    task automatic test_full_push_pop();
        int   widths [4] = '{12, 12, 25, 25};
        logic exp_code [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int   s, r, d;
        bus.accept_en = 1'b0;
        foreach (widths[i]) begin
            drive_pulse(widths[i], d);
            idle(14);
        end
        s = code_q.size();
        r = rej_cnt;
        drive_pulse(12, d);
        // Push reaches the full FIFO 9 edges after the drop; open accept_en for exactly that edge.
        repeat (8) @(posedge clk);
        #1 bus.accept_en = 1'b1;
        @(posedge clk);
        #1 bus.accept_en = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (bus.coins_queued !== 3'd4 || rej_cnt - r !== 0) begin
            n_fail++;
            $display("FAIL full_pushpop: got queued=%0d rejects=%0d required 4/0",
                     bus.coins_queued, rej_cnt - r);
        end
        n_vec++;
        if (code_q.size() - s !== 1 || stamp_q[stamp_q.size()-1] - d !== 9) begin
            n_fail++;
            $display("FAIL full_pop_strobe: got strobes=%0d required 1 at drop+9",
                     code_q.size() - s);
        end
        bus.accept_en = 1'b1;
        idle(25);
        n_vec++;
        if (code_q.size() - s !== 5) begin
            n_fail++;
            $display("FAIL full_drain_count: got %0d required 5", code_q.size() - s);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (code_q[s+i] !== exp_code[i]) begin
                    n_fail++;
                    $display("FAIL full_order_%0d: got %0d required %0d",
                             i, code_q[s+i], exp_code[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        int s, r, d;
        bus.accept_en = 1'b0;
        drive_pulse(12, d);
        idle(14);
        drive_pulse(25, d);
        idle(14);
        n_vec++;
        if (bus.coins_queued !== 3'd2) begin
            n_fail++;
            $display("FAIL mid_queued: got %0d required 2", bus.coins_queued);
        end
        s = code_q.size();
        r = rej_cnt;
        @(posedge clk);
        #1 bus.coin_sense = 1'b1;
        idle(10);
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.coins_queued !== 3'd0 || bus.five_rup !== 1'b0 || bus.ten_rup !== 1'b0 ||
            bus.coin_reject !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got queued=%0d strobes=%b%b%b required 0/000",
                     bus.coins_queued, bus.five_rup, bus.ten_rup, bus.coin_reject);
        end
        bus.coin_sense = 1'b0;
        idle(3);
        rst_n = 1'b1;
        bus.accept_en = 1'b1;
        idle(25);
        n_vec++;
        if (code_q.size() - s !== 0 || rej_cnt - r !== 0) begin
            n_fail++;
            $display("FAIL mid_after_release: got strobes=%0d rejects=%0d required 0/0",
                     code_q.size() - s, rej_cnt - r);
        end
        drive_pulse(12, d);
        idle(20);
        n_vec++;
        if (code_q.size() - s !== 1 || code_q[code_q.size()-1] !== COIN_FIVE) begin
            n_fail++;
            $display("FAIL mid_next_coin: got strobes=%0d required one five", code_q.size() - s);
        end
    endtask

    task automatic test_sense_high_at_release();
        int s, r, d;
        s = code_q.size();
        r = rej_cnt;
        bus.coin_sense = 1'b1;
        #1 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(20);
        bus.coin_sense = 1'b0;
        idle(25);
        n_vec++;
        if (code_q.size() - s !== 0 || rej_cnt - r !== 0) begin
            n_fail++;
            $display("FAIL partial_coin: got strobes=%0d rejects=%0d required 0/0",
                     code_q.size() - s, rej_cnt - r);
        end
        drive_pulse(25, d);
        idle(20);
        n_vec++;
        if (code_q.size() - s !== 1 || code_q[code_q.size()-1] !== COIN_TEN) begin
            n_fail++;
            $display("FAIL after_partial: got strobes=%0d required one ten", code_q.size() - s);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_five();
        test_ten_and_glitch();
        test_invalid();
        test_queue_overflow();
        test_full_push_pop();
        test_reset_mid_flight();
        test_sense_high_at_release();
        n_vec++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL strobe_overlap: got %0d required 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
